// File: rtl/alsu_rr_scheduler_pkg.sv
// alsu_rr_scheduler_pkg
// Shared definitions for the ALSU round-robin scheduler: command word layout,
// ALSU opcode values, FSM state encoding and the invalid-command predicate.
package alsu_rr_scheduler_pkg;

  localparam int CMD_W    = 16;
  localparam int OPC_LSB  = 0;
  localparam int A_LSB    = 3;
  localparam int B_LSB    = 6;
  localparam int CIN_BIT  = 9;
  localparam int SER_BIT  = 10;
  localparam int DIR_BIT  = 11;
  localparam int REDA_BIT = 12;
  localparam int REDB_BIT = 13;
  localparam int BYPA_BIT = 14;
  localparam int BYPB_BIT = 15;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_XOR   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_ROT   = 3'b101;
  localparam logic [2:0] OP_INV6  = 3'b110;
  localparam logic [2:0] OP_INV7  = 3'b111;

  // Idle command: only byp_A set, so the ALSU passes A (=0) straight through.
  localparam logic [CMD_W-1:0] CMD_IDLE = CMD_W'(1) << BYPA_BIT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A command is invalid when the ALSU would route it to its Invalid case.
  // Any bypass bit overrides the opcode, so bypassed commands are always valid.
  function automatic logic is_invalid_cmd(input logic [CMD_W-1:0] cmd);
    logic [2:0] op;
    logic       red_any;
    op      = cmd[OPC_LSB +: 3];
    red_any = cmd[REDA_BIT] | cmd[REDB_BIT];
    if (cmd[BYPA_BIT] || cmd[BYPB_BIT]) begin
      return 1'b0;
    end
    if (op == OP_INV6 || op == OP_INV7) begin
      return 1'b1;
    end
    if (op >= OP_ADD && op <= OP_ROT && red_any) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/alsu_rr_scheduler_if.sv
// alsu_rr_scheduler_if
// Requester/response bus of the ALSU scheduler.
//   req_valid/req_cmd/req_ready : per-requester command handshake
//   rsp_valid/rsp_ready         : response handshake
//   rsp_id/rsp_data/rsp_err     : response payload
// master = requesters + response consumer, slave = scheduler.
interface alsu_rr_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [5:0]          rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alsu_rr_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: first set bit of req_i at or after ptr_i,
// wrapping from N_REQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < N_REQ)
//   grant_o : one-hot grant
//   idx_o   : index of the granted bit
//   any_o   : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alsu_rr_scheduler.sv
// alsu_rr_scheduler
// Shares one ALSU among N_REQ requesters. A round-robin arbiter accepts one
// command at a time; valid commands are driven to the ALSU for ALSU_LAT
// cycles and the ALSU result is returned tagged with the requester id.
// Commands the ALSU would treat as Invalid are answered locally with rsp_err.
//   CLK, RST_n          : clock, asynchronous active-low reset
//   bus (slave)         : request/response handshake, see alsu_rr_scheduler_if
//   alsu_A .. alsu_byp_B: ALSU inputs, held from the last accepted valid cmd
//   alsu_out            : ALSU result
module alsu_rr_scheduler
  import alsu_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ALSU_LAT = 3,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                RST_n,
  alsu_rr_scheduler_if.slave  bus,
  output logic [2:0]          alsu_A,
  output logic [2:0]          alsu_B,
  output logic [2:0]          alsu_opcode,
  output logic                alsu_cin,
  output logic                alsu_serial_in,
  output logic                alsu_dir,
  output logic                alsu_red_A,
  output logic                alsu_red_B,
  output logic                alsu_byp_A,
  output logic                alsu_byp_B,
  input  logic [5:0]          alsu_out
);

  localparam int LAT_W = $clog2(ALSU_LAT + 1);

  state_t           state_q;
  logic [CMD_W-1:0] cmd_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             rsp_valid_q;
  logic [5:0]       rsp_data_q;
  logic             rsp_err_q;

  logic [CMD_W-1:0] cmd_arr [N_REQ];
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [CMD_W-1:0] sel_cmd;
  logic             sel_invalid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cmd_unpack
    assign cmd_arr[gi] = bus.req_cmd[CMD_W*gi +: CMD_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign sel_cmd     = cmd_arr[grant_idx];
  assign sel_invalid = is_invalid_cmd(sel_cmd);
  assign rr_ptr_d    = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);

  // Gated by RST_n so a requester never sees an accept while the FSM is held
  // in reset and cannot actually latch its command.
  assign bus.req_ready = (state_q == ST_IDLE && RST_n) ? grant : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_IDLE;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      lat_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            if (sel_invalid) begin
              // cmd_q is left alone so the ALSU never sees a rejected command.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              state_q     <= ST_RESP;
            end else begin
              cmd_q     <= sel_cmd;
              lat_cnt_q <= LAT_W'(ALSU_LAT - 1);
              state_q   <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (lat_cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= alsu_out;
            state_q     <= ST_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alsu_opcode    = cmd_q[OPC_LSB +: 3];
  assign alsu_A         = cmd_q[A_LSB +: 3];
  assign alsu_B         = cmd_q[B_LSB +: 3];
  assign alsu_cin       = cmd_q[CIN_BIT];
  assign alsu_serial_in = cmd_q[SER_BIT];
  assign alsu_dir       = cmd_q[DIR_BIT];
  assign alsu_red_A     = cmd_q[REDA_BIT];
  assign alsu_red_B     = cmd_q[REDB_BIT];
  assign alsu_byp_A     = cmd_q[BYPA_BIT];
  assign alsu_byp_B     = cmd_q[BYPB_BIT];

endmodule

// File: tb/tb_alsu_rr_scheduler.sv
// tb_alsu_rr_scheduler
// Directed bench for alsu_rr_scheduler with a behavioural ALSU behind it.
// The ALSU model registers its inputs, then registers the result, so a value
// driven after the grant edge is available to be captured ALSU_LAT edges later.
module tb_alsu_rr_scheduler;

  localparam int N_REQ    = 4;
  localparam int ALSU_LAT = 3;
  localparam int ID_W     = 2;

  logic       CLK;
  logic       RST_n;
  logic [2:0] alsu_A, alsu_B, alsu_opcode;
  logic       alsu_cin, alsu_serial_in, alsu_dir;
  logic       alsu_red_A, alsu_red_B, alsu_byp_A, alsu_byp_B;
  logic [5:0] alsu_out;

  int compared   = 0;
  int mismatched = 0;

  alsu_rr_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  alsu_rr_scheduler #(
    .N_REQ    (N_REQ),
    .ALSU_LAT (ALSU_LAT),
    .ID_W     (ID_W)
  ) dut (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .bus            (bus),
    .alsu_A         (alsu_A),
    .alsu_B         (alsu_B),
    .alsu_opcode    (alsu_opcode),
    .alsu_cin       (alsu_cin),
    .alsu_serial_in (alsu_serial_in),
    .alsu_dir       (alsu_dir),
    .alsu_red_A     (alsu_red_A),
    .alsu_red_B     (alsu_red_B),
    .alsu_byp_A     (alsu_byp_A),
    .alsu_byp_B     (alsu_byp_B),
    .alsu_out       (alsu_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural ALSU ----------------
  logic [2:0] m_op, m_a, m_b;
  logic       m_cin, m_ser, m_dir, m_ra, m_rb, m_ba, m_bb;

  function automatic logic [5:0] alsu_f(
    input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
    input logic cin, input logic ser, input logic dir,
    input logic ra, input logic rb, input logic ba, input logic bb,
    input logic [5:0] prev);
    logic [5:0] r;
    r = 6'd0;
    if (ba) r = {3'b0, a};
    else if (bb) r = {3'b0, b};
    else begin
      case (op)
        3'b000: r = ra ? {5'b0, &a} : rb ? {5'b0, &b} : {3'b0, a & b};
        3'b001: r = ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
        3'b010: r = 6'(a) + 6'(b) + 6'(cin);
        3'b011: r = 6'(a) * 6'(b);
        3'b100: r = dir ? {prev[4:0], ser} : {ser, prev[5:1]};
        3'b101: r = dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        default: r = 6'd0;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_op <= '0; m_a <= '0; m_b <= '0;
      m_cin <= 1'b0; m_ser <= 1'b0; m_dir <= 1'b0;
      m_ra <= 1'b0; m_rb <= 1'b0; m_ba <= 1'b0; m_bb <= 1'b0;
      alsu_out <= '0;
    end else begin
      m_op <= alsu_opcode; m_a <= alsu_A; m_b <= alsu_B;
      m_cin <= alsu_cin; m_ser <= alsu_serial_in; m_dir <= alsu_dir;
      m_ra <= alsu_red_A; m_rb <= alsu_red_B; m_ba <= alsu_byp_A; m_bb <= alsu_byp_B;
      alsu_out <= alsu_f(m_op, m_a, m_b, m_cin, m_ser, m_dir, m_ra, m_rb, m_ba, m_bb, alsu_out);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant in IDLE; returns the granted index or -1 on timeout.
  task automatic wait_grant(output int idx);
    bit found;
    found = 1'b0;
    idx   = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK); #1;
      if (bus.req_ready != '0) begin
        found = 1'b1;
        for (int b = 0; b < N_REQ; b++) if (bus.req_ready[b]) idx = b;
      end
    end
  endtask

  // Counts negedges until rsp_valid; returns 99 on timeout.
  task automatic wait_rsp(output int n);
    bit found;
    found = 1'b0;
    n     = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge CLK); #1;
      if (bus.rsp_valid) begin
        found = 1'b1;
        n     = i;
      end
    end
    $display("rsp id=%0d data=%0h err=%0b after %0d cycles",
             bus.rsp_id, bus.rsp_data, bus.rsp_err, n);
  endtask

  int idx;
  int n;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    RST_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("rst_byp_A",     32'(alsu_byp_A),    32'h1);
    chk("rst_opcode",    32'(alsu_opcode),   32'h0);
    RST_n = 1'b1;

    // ---- single AND on req0: A=3, B=5 -> 1 ----
    @(negedge CLK); #1;
    bus.req_cmd[15:0] = 16'h0158;
    bus.req_valid     = 4'b0001;
    bus.rsp_ready     = 1'b1;
    #1;
    $display("req id=0 cmd=%04h", 16'h0158);
    chk("and_grant", 32'(bus.req_ready), 32'h1);
    @(posedge CLK); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    chk("and_latency", 32'(n), 32'(1 + ALSU_LAT));
    chk("and_id",   32'(bus.rsp_id),   32'h0);
    chk("and_data", 32'(bus.rsp_data), 32'h1);
    chk("and_err",  32'(bus.rsp_err),  32'h0);
    @(negedge CLK); #1;
    chk("and_resp_1cycle", 32'(bus.rsp_valid), 32'h0);

    // ---- invalid on req2: ADD with red_A -> rejected ----
    bus.req_cmd[47:32] = 16'h1002;
    bus.req_valid      = 4'b0100;
    #1;
    $display("req id=2 cmd=%04h", 16'h1002);
    chk("inv_grant", 32'(bus.req_ready), 32'h4);
    @(posedge CLK); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    chk("inv_latency", 32'(n), 32'h1);
    chk("inv_id",   32'(bus.rsp_id),   32'h2);
    chk("inv_err",  32'(bus.rsp_err),  32'h1);
    chk("inv_data", 32'(bus.rsp_data), 32'h0);
    chk("inv_alsu_opcode", 32'(alsu_opcode), 32'h0);
    chk("inv_alsu_A",      32'(alsu_A),      32'h3);
    chk("inv_alsu_B",      32'(alsu_B),      32'h5);

    // ---- bypass B on req1: opcode 111, B=4 -> 4 (pointer wraps 3->0->1) ----
    @(negedge CLK); #1;
    bus.req_cmd[31:16] = 16'h8107;
    bus.req_valid      = 4'b0010;
    #1;
    $display("req id=1 cmd=%04h", 16'h8107);
    chk("byp_grant", 32'(bus.req_ready), 32'h2);
    @(posedge CLK); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    chk("byp_latency", 32'(n), 32'(1 + ALSU_LAT));
    chk("byp_id",   32'(bus.rsp_id),   32'h1);
    chk("byp_err",  32'(bus.rsp_err),  32'h0);
    chk("byp_data", 32'(bus.rsp_data), 32'h4);
    @(negedge CLK); #1;

    // ---- backpressure on req3: XOR 6^3 -> 5, rsp_ready low 5 cycles ----
    bus.req_cmd[63:48] = 16'h00F1;
    bus.req_valid      = 4'b1000;
    bus.rsp_ready      = 1'b0;
    #1;
    $display("req id=3 cmd=%04h", 16'h00F1);
    chk("bp_grant", 32'(bus.req_ready), 32'h8);
    @(posedge CLK); #1;
    bus.req_cmd[15:0] = 16'h0042;
    bus.req_valid     = 4'b0001;
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'(1 + ALSU_LAT));
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_rsp_id",    32'(bus.rsp_id),    32'h3);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'h5);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end

    // ---- round robin: all four ADD A=i,B=1 -> i+1 ----
    bus.req_cmd   = {16'h005A, 16'h0052, 16'h004A, 16'h0042};
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(idx);
      $display("grant id=%0d", idx);
      chk("rr_grant", 32'(idx), 32'(exp_order[k]));
      wait_rsp(n);
      chk("rr_latency", 32'(n), 32'(1 + ALSU_LAT));
      chk("rr_id",   32'(bus.rsp_id),   32'(exp_order[k]));
      chk("rr_data", 32'(bus.rsp_data), 32'(exp_order[k] + 1));
    end
    wait_grant(idx);
    $display("grant id=%0d", idx);
    chk("rr_wrap_grant", 32'(idx), 32'(exp_order[4]));

    // ---- reset one cycle after that grant (in DRIVE) ----
    @(posedge CLK); #1;
    RST_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_mid_byp_A",     32'(alsu_byp_A),    32'h1);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    RST_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    wait_rsp(n);
    chk("post_rst_latency", 32'(n), 32'(1 + ALSU_LAT));
    chk("post_rst_id",   32'(bus.rsp_id),   32'h0);
    chk("post_rst_data", 32'(bus.rsp_data), 32'h1);
    @(negedge CLK); #1;
    bus.req_valid = '0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
